// File: rtl/cdb_broadcast_pkg.sv
// Shared constants and FU encoding for the issue unit and the common data bus.
package cdb_broadcast_pkg;

  localparam int ROB_TAG_LEN = 6;
  localparam int XLEN        = 32;
  localparam int NUM_FU      = 4;

  typedef enum logic [1:0] {
    FU_INT = 2'd0,
    FU_BR  = 2'd1,
    FU_LS  = 2'd2,
    FU_MUL = 2'd3
  } fu_id_t;

endpackage

// File: rtl/cdb_broadcast_rr_arbiter4.sv
// Four-way round-robin pick: first requester at or after ptr, wrapping modulo 4.
module rr_arbiter4 (
  input  logic [3:0] request,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       any_grant
);

  logic [1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!any_grant && request[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcast.sv
// Common data bus: one holding buffer per FU, round-robin drain onto a registered broadcast.
// Handshake: FU i hands over a result on an edge where fu_valid[i] && fu_ready[i].
module cdb_broadcast
  import cdb_broadcast_pkg::*;
#(
  parameter int XLEN = cdb_broadcast_pkg::XLEN
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]          fu_value,
  output logic [NUM_FU-1:0]                    fu_ready,
  input  logic                                 flush,
  output logic                                 cdb_valid,
  output logic [ROB_TAG_LEN-1:0]               cdb_tag,
  output logic [XLEN-1:0]                      cdb_value,
  output logic [1:0]                           cdb_src
);

  logic [NUM_FU-1:0]                  full_q;
  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0] tag_q;
  logic [NUM_FU-1:0][XLEN-1:0]        value_q;
  logic [1:0]                         rr_ptr_q;

  logic [NUM_FU-1:0] grant;
  logic [1:0]        grant_idx;
  logic              any_grant;
  logic [NUM_FU-1:0] accept;

  rr_arbiter4 u_arb (
    .request   (full_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A buffer being drained this edge can take a new result at the same edge.
  assign fu_ready = flush ? '0 : (~full_q | grant);
  assign accept   = fu_valid & fu_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q    <= '0;
      tag_q     <= '0;
      value_q   <= '0;
      rr_ptr_q  <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      full_q    <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          full_q[i]  <= 1'b1;
          tag_q[i]   <= fu_tag[i];
          value_q[i] <= fu_value[i];
        end else if (grant[i]) begin
          full_q[i] <= 1'b0;
        end
      end
      if (any_grant) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= tag_q[grant_idx];
        cdb_value <= value_q[grant_idx];
        cdb_src   <= grant_idx;
        rr_ptr_q  <= grant_idx + 2'd1;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Directed bench for cdb_broadcast with hand-computed expected broadcasts.
module tb_cdb_broadcast;
  import cdb_broadcast_pkg::*;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [3:0]                       fu_valid;
  logic [3:0][ROB_TAG_LEN-1:0]      fu_tag;
  logic [3:0][31:0]                 fu_value;
  logic [3:0]                       fu_ready;
  logic                             flush;
  logic                             cdb_valid;
  logic [ROB_TAG_LEN-1:0]           cdb_tag;
  logic [31:0]                      cdb_value;
  logic [1:0]                       cdb_src;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_broadcast #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_value  (fu_value),
    .fu_ready  (fu_ready),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic f);
    fu_valid = v;
    flush    = f;
    #1;
  endtask

  task automatic set_fu(input int i, input int t);
    fu_tag[i]   = ROB_TAG_LEN'(t);
    fu_value[i] = 32'hA000_0000 | 32'(t);
  endtask

  task automatic chk_cdb(input string tag, input logic v, input int t, input int s);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'(v));
    chk({tag, "_tag"},   64'(cdb_tag),   64'(t));
    chk({tag, "_src"},   64'(cdb_src),   64'(s));
    if (v) chk({tag, "_value"}, 64'(cdb_value), 64'(32'hA000_0000 | 32'(t)));
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    fu_valid = '0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    fu_tag   = '0;
    fu_value = '0;
    reset_dut();

    // Reset state
    chk("rst_valid", 64'(cdb_valid), 64'(0));
    chk("rst_tag",   64'(cdb_tag),   64'(0));
    chk("rst_value", 64'(cdb_value), 64'(0));
    chk("rst_src",   64'(cdb_src),   64'(0));
    chk("rst_ready", 64'(fu_ready),  64'(4'b1111));
    chk("rst_ptr",   64'(dut.rr_ptr_q), 64'(0));

    // Single INT result: tag 5, value 0x1234
    fu_tag[0]   = ROB_TAG_LEN'(5);
    fu_value[0] = 32'h1234;
    drive(4'b0001, 1'b0);
    tick();
    drive(4'b0000, 1'b0);
    chk("t1_lat_valid", 64'(cdb_valid), 64'(0));
    tick();
    chk("t1_valid", 64'(cdb_valid), 64'(1));
    chk("t1_tag",   64'(cdb_tag),   64'(5));
    chk("t1_value", 64'(cdb_value), 64'(32'h1234));
    chk("t1_src",   64'(cdb_src),   64'(0));
    tick();
    chk("t1_after_valid", 64'(cdb_valid), 64'(0));
    chk("t1_after_tag",   64'(cdb_tag),   64'(5));

    // All four at once from rr_ptr 0
    reset_dut();
    for (int i = 0; i < 4; i++) set_fu(i, i + 1);
    drive(4'b1111, 1'b0);
    chk("t2_ready_empty", 64'(fu_ready), 64'(4'b1111));
    tick();
    drive(4'b0000, 1'b0);
    chk("t2_ready_full", 64'(fu_ready), 64'(4'b0001));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_cdb($sformatf("t2_b%0d", k), 1'b1, k + 1, k);
    end
    tick();
    chk("t2_idle_valid", 64'(cdb_valid), 64'(0));
    chk("t2_ptr", 64'(dut.rr_ptr_q), 64'(0));

    // MUL back-to-back: tags 8, 9, 10
    set_fu(3, 8);
    drive(4'b1000, 1'b0);
    chk("t3_ready0", 64'(fu_ready[3]), 64'(1));
    tick();
    set_fu(3, 9);
    #1;
    chk("t3_ready1", 64'(fu_ready[3]), 64'(1));
    tick();
    chk_cdb("t3_b8", 1'b1, 8, 3);
    set_fu(3, 10);
    #1;
    chk("t3_ready2", 64'(fu_ready[3]), 64'(1));
    tick();
    chk_cdb("t3_b9", 1'b1, 9, 3);
    drive(4'b0000, 1'b0);
    tick();
    chk_cdb("t3_b10", 1'b1, 10, 3);
    tick();
    chk("t3_idle_valid", 64'(cdb_valid), 64'(0));

    // Move rr_ptr to 2 via a BR broadcast, then LS full against INT+BR
    set_fu(1, 20);
    drive(4'b0010, 1'b0);
    tick();
    drive(4'b0000, 1'b0);
    tick();
    chk_cdb("t4_b20", 1'b1, 20, 1);
    chk("t4_ptr2", 64'(dut.rr_ptr_q), 64'(2));
    set_fu(2, 30);
    drive(4'b0100, 1'b0);
    tick();
    chk("t4_accept_valid", 64'(cdb_valid), 64'(0));
    set_fu(0, 11);
    set_fu(1, 12);
    drive(4'b0011, 1'b0);
    chk("t4_ready_contend", 64'(fu_ready), 64'(4'b1111));
    tick();
    chk_cdb("t4_b30", 1'b1, 30, 2);
    drive(4'b0000, 1'b0);
    chk("t4_ready_wait", 64'(fu_ready), 64'(4'b1101));
    tick();
    chk_cdb("t4_b11", 1'b1, 11, 0);
    chk("t4_ready_br", 64'(fu_ready), 64'(4'b1111));
    tick();
    chk_cdb("t4_b12", 1'b1, 12, 1);
    tick();
    chk("t4_idle_valid", 64'(cdb_valid), 64'(0));

    // Flush with INT and MUL buffers full; a new INT offer during flush is refused
    set_fu(0, 40);
    set_fu(3, 41);
    drive(4'b1001, 1'b0);
    tick();
    set_fu(0, 42);
    drive(4'b0001, 1'b1);
    chk("t5_ready_flush", 64'(fu_ready), 64'(4'b0000));
    tick();
    chk("t5_valid_flush", 64'(cdb_valid), 64'(0));
    drive(4'b0000, 1'b0);
    chk("t5_ready_after", 64'(fu_ready), 64'(4'b1111));
    chk("t5_ptr_hold", 64'(dut.rr_ptr_q), 64'(2));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_quiet%0d", k), 64'(cdb_valid), 64'(0));
    end

    // Async reset with three buffers full and a broadcast on the bus
    for (int i = 0; i < 3; i++) set_fu(i, 50 + i);
    drive(4'b0111, 1'b0);
    tick();
    set_fu(3, 53);
    drive(4'b1000, 1'b0);
    tick();
    chk_cdb("t6_b52", 1'b1, 52, 2);
    drive(4'b0000, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(cdb_valid), 64'(0));
    chk("t6_rst_tag",   64'(cdb_tag),   64'(0));
    chk("t6_rst_value", 64'(cdb_value), 64'(0));
    chk("t6_rst_src",   64'(cdb_src),   64'(0));
    chk("t6_rst_ready", 64'(fu_ready),  64'(4'b1111));
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rel_ready", 64'(fu_ready), 64'(4'b1111));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t6_quiet%0d", k), 64'(cdb_valid), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_broadcast.md
CDB_BROADCAST -- requirements
Module: cdb_broadcast

Interface
REQ-001 Parameter XLEN, default 32: result value width.
REQ-002 Parameter NUM_FU, fixed 4: FU ports; index 0 INT, 1 BRANCH, 2 LD/ST, 3 MUL (same encoding as issue select_signal).
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 fu_valid  in  [3:0]  FU i presents a completed result.
REQ-006 fu_tag  in  [3:0][ROB_TAG_LEN-1:0]  ROB tag of each FU result.
REQ-007 fu_value  in  [3:0][XLEN-1:0]  result value of each FU.
REQ-008 fu_ready  out  [3:0]  FU i result is accepted this cycle when fu_valid[i] is also high.
REQ-009 flush  in  1  mispredict squash; discards all pending results.
REQ-010 cdb_valid  out  1  broadcast valid.
REQ-011 cdb_tag  out  ROB_TAG_LEN  broadcast ROB tag.
REQ-012 cdb_value  out  XLEN  broadcast value.
REQ-013 cdb_src  out  2  FU index of the broadcast.

Function
REQ-014 Each FU has a one-entry holding buffer: full bit, tag, value.
REQ-015 fu_ready[i] = !flush && (!full[i] || grant[i]), combinational.
REQ-016 fu_valid[i] && fu_ready[i] at an edge loads buffer i and sets full[i] at that edge.
REQ-017 Round-robin arbiter: grant goes to the first full buffer at or after rr_ptr, modulo 4. At most one grant per cycle.
REQ-018 On grant to i at an edge, cdb_valid<=1, cdb_tag/value<=buffer i, cdb_src<=i, rr_ptr<=(i+1) mod 4, full[i]<=0 unless reloaded the same edge.
REQ-019 No full buffer: cdb_valid<=0. rr_ptr, cdb_tag, cdb_value and cdb_src hold.
REQ-020 Latency: a result accepted at edge N with no contention is broadcast at edge N+1 and visible for exactly one cycle.
REQ-021 Simultaneous accept and grant on the same port is legal. The new result is broadcast no earlier than the following edge.
REQ-022 All four buffers full: served in four consecutive cycles in rr order. No FU waits more than 4 broadcast cycles.
REQ-023 Outputs are registered. cdb_valid is never high for the same tag twice from one acceptance.
REQ-024 flush at an edge: all full<=0, cdb_valid<=0. No new accepts that cycle. rr_ptr holds.
REQ-025 A broadcast already registered before the flush edge is still visible for its cycle; the ROB discards it.

Reset
REQ-026 reset clears all full bits and sets rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0.
REQ-027 Reset mid-operation discards pending results without a broadcast.
REQ-028 fu_ready is high on the first cycle after reset release.

Structure
REQ-029 The shared package holds ROB_TAG_LEN, XLEN, NUM_FU and the fu_id_t enum (INT=0, BR=1, LS=2, MUL=3), reused by the issue unit.
REQ-030 One sub-module, rr_arbiter4: request[3:0], ptr[1:0] -> grant one-hot, grant_idx[1:0], any_grant. Purely combinational.

Verification
REQ-031 Single INT result, tag 5, value 0x1234, valid one cycle, idle otherwise -> cdb_valid one cycle later with tag 5, value 0x1234, src 0; then cdb_valid 0.
REQ-032 All four FUs valid same cycle, tags 1..4, rr_ptr=0 -> broadcasts on four consecutive cycles of tags 1,2,3,4, src 0..3; rr_ptr ends 0.
REQ-033 MUL holds fu_valid continuously with tags 8,9,10, INT idle -> one broadcast per cycle; fu_ready[3] stays 1.
REQ-034 LS buffer full and INT+BR contending with rr_ptr=2 -> LS granted first; fu_ready low for waiting full ports until granted.
REQ-035 Two buffers full, flush pulsed -> next cycle cdb_valid=0, no later broadcast of those tags; fu_ready=0 during flush.
REQ-036 reset asserted asynchronously while three buffers are full -> outputs zero immediately, no broadcast after release, fu_ready=4'b1111.
